// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: valid-bit tracking and stall/clear/flush/drain control for a
// DEPTH-stage data pipeline. A word accepted upstream appears at the last stage
// DEPTH cycles later when nothing stalls.
// Optional build macro PIPELINE_CTRL_STALL_STATS_EN adds o_stall_cycles, a
// saturating 16-bit count of stalled cycles.
module pipeline_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  input  logic        i_flush,
  input  logic        i_drain,
  output logic        o_stall,
  output logic        o_clear,
  output logic        o_drained,
`ifdef PIPELINE_CTRL_STALL_STATS_EN
  output logic [15:0] o_stall_cycles,
`endif
  output logic [4:0]  o_occupancy
);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [DEPTH-1:0] vld_pipe, vld_nxt;
  logic             accept, consume, drained_nxt;

  // Clear must win over hold, so nothing stalls or leaves the pipe in FLUSH.
  assign o_out_valid = vld_pipe[DEPTH-1] && (state != FLUSH);
  assign o_stall     = vld_pipe[DEPTH-1] && !i_out_ready && (state != FLUSH);
  assign o_in_ready  = !o_stall && (state == RUN);
  assign o_clear     = (state == FLUSH);
  assign accept      = i_in_valid && o_in_ready;
  assign consume     = o_out_valid && i_out_ready;

  // Next valid vector: wipe on flush, hold on stall, otherwise advance one stage.
  always_comb begin
    vld_nxt = vld_pipe;
    if (state == FLUSH) begin
      vld_nxt = '0;
    end else if (!o_stall) begin
      vld_nxt[0] = accept;
      for (int k = 1; k < DEPTH; k++) vld_nxt[k] = vld_pipe[k-1];
    end
  end

  // Mode sequencing; flush outranks drain, drain ends once the pipe is empty.
  always_comb begin
    state_nxt   = state;
    drained_nxt = 1'b0;
    case (state)
      RUN: begin
        if (i_flush)      state_nxt = FLUSH;
        else if (i_drain) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (i_flush) begin
          state_nxt = FLUSH;
        end else if (o_occupancy == 5'd0) begin
          state_nxt   = RUN;
          drained_nxt = 1'b1;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State, valid vector and drain-complete pulse registers.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state     <= RUN;
      vld_pipe  <= '0;
      o_drained <= 1'b0;
    end else begin
      state     <= state_nxt;
      vld_pipe  <= vld_nxt;
      o_drained <= drained_nxt;
    end
  end

  // Occupancy counter; tracks popcount of the valid vector without an adder tree.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_occupancy <= 5'd0;
    end else if (state == FLUSH) begin
      o_occupancy <= 5'd0;
    end else begin
      case ({accept, consume})
        2'b10:   o_occupancy <= o_occupancy + 5'd1;
        2'b01:   o_occupancy <= o_occupancy - 5'd1;
        default: o_occupancy <= o_occupancy;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_STALL_STATS_EN
  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)                              o_stall_cycles <= 16'd0;
    else if (o_stall && o_stall_cycles != 16'hFFFF) o_stall_cycles <= o_stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic against a queue-of-word-ages reference model.
module tb_pipeline_ctrl;
  localparam int DEPTH = 4;

  logic       i_clk = 1'b0;
  logic       i_resetn, i_in_valid, i_out_ready, i_flush, i_drain;
  logic       o_in_ready, o_out_valid, o_stall, o_clear, o_drained;
  logic [4:0] o_occupancy;
`ifdef PIPELINE_CTRL_STALL_STATS_EN
  logic [15:0] o_stall_cycles;
`endif

  int tests_run = 0, tests_failed = 0;

  always #5 i_clk = ~i_clk;

  pipeline_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_resetn(i_resetn), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .i_flush(i_flush), .i_drain(i_drain), .o_stall(o_stall), .o_clear(o_clear),
    .o_drained(o_drained),
`ifdef PIPELINE_CTRL_STALL_STATS_EN
    .o_stall_cycles(o_stall_cycles),
`endif
    .o_occupancy(o_occupancy));

  // Reference model: each in-flight word carries its age (stages travelled).
  // A word of age DEPTH sits at the output. Mode: 0 run, 1 drain, 2 flush.
  int q[$];
  int m_mode, m_stall_cnt;
  bit m_drained;
  bit e_ov, e_stall, e_ir, e_clr, e_drn;
  int e_occ;

  function automatic void model_reset();
    q.delete(); m_mode = 0; m_drained = 0; m_stall_cnt = 0;
  endfunction

  // Drive one cycle's inputs and derive the expected outputs for it.
  task automatic apply(input bit inv, input bit ordy, input bit fl, input bit dr);
    bit at_out;
    i_in_valid = inv; i_out_ready = ordy; i_flush = fl; i_drain = dr;
    at_out  = (q.size() > 0) && (q[0] == DEPTH);
    e_ov    = at_out && (m_mode != 2);
    e_stall = e_ov && !ordy;
    e_ir    = !e_stall && (m_mode == 0);
    e_clr   = (m_mode == 2);
    e_occ   = q.size();
    e_drn   = m_drained;
    #1;
  endtask

  // Advance the model over the clock edge, then move to the next falling edge.
  task automatic tick();
    int nmode, occ;
    occ = q.size();
    case (m_mode)
      0:       nmode = i_flush ? 2 : (i_drain ? 1 : 0);
      1:       nmode = i_flush ? 2 : ((occ == 0) ? 0 : 1);
      default: nmode = 0;
    endcase
    m_drained = (m_mode == 1) && !i_flush && (occ == 0);
    if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (m_mode == 2) q.delete();
    else if (!e_stall) begin
      if (e_ov) void'(q.pop_front());
      foreach (q[i]) q[i]++;
      if (i_in_valid && e_ir) q.push_back(1);
    end
    m_mode = nmode;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin apply(0, 1, 0, 0); tick(); end
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (o_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); end
    tests_run++; if (o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    tests_run++; if (o_stall !== 1'b0 || o_clear !== 1'b0) begin tests_failed++; $display("FAIL reset_stall_clear got=%b%b exp=00", o_stall, o_clear); end
    tests_run++; if (o_occupancy !== 5'd0 || o_drained !== 1'b0) begin tests_failed++; $display("FAIL reset_occ_drained got=%0d/%b exp=0/0", o_occupancy, o_drained); end
`ifdef PIPELINE_CTRL_STALL_STATS_EN
    tests_run++; if (o_stall_cycles !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_cycles got=%0d exp=0", o_stall_cycles); end
`endif
    @(negedge i_clk);
    i_resetn = 1'b1;
  endtask

  task automatic test_fill();
    int first, high, peak;
    first = -1; high = 0; peak = 0;
    idle(2);
    for (int c = 0; c < 16; c++) begin
      apply(c < 6, 1, 0, 0);
      tests_run++; if (o_out_valid !== e_ov) begin tests_failed++; $display("FAIL fill_out_valid cyc=%0d got=%b exp=%b", c, o_out_valid, e_ov); end
      if (o_out_valid) begin if (first < 0) first = c; high++; end
      if (int'(o_occupancy) > peak) peak = o_occupancy;
      tick();
    end
    tests_run++; if (first !== DEPTH) begin tests_failed++; $display("FAIL fill_latency got=%0d exp=%0d", first, DEPTH); end
    tests_run++; if (high !== 6) begin tests_failed++; $display("FAIL fill_high_cycles got=%0d exp=6", high); end
    tests_run++; if (peak !== DEPTH) begin tests_failed++; $display("FAIL fill_peak_occ got=%0d exp=%0d", peak, DEPTH); end
  endtask

  task automatic test_stall();
    int base, outs;
    idle(8);
    base = m_stall_cnt;
    for (int c = 0; c < DEPTH; c++) begin apply(1, 0, 0, 0); tick(); end
    for (int c = 0; c < 3; c++) begin
      apply(1, 0, 0, 0);
      tests_run++; if (o_stall !== 1'b1 || o_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_hold cyc=%0d got stall=%b in_ready=%b exp 1/0", c, o_stall, o_in_ready); end
      tests_run++; if (o_occupancy !== 5'(DEPTH)) begin tests_failed++; $display("FAIL stall_occ cyc=%0d got=%0d exp=%0d", c, o_occupancy, DEPTH); end
      tick();
    end
    apply(0, 1, 0, 0);
    tests_run++; if (o_stall !== 1'b0) begin tests_failed++; $display("FAIL stall_release got=%b exp=0", o_stall); end
`ifdef PIPELINE_CTRL_STALL_STATS_EN
    tests_run++; if (int'(o_stall_cycles) !== base + 3) begin tests_failed++; $display("FAIL stall_cycles got=%0d exp=%0d", o_stall_cycles, base + 3); end
`endif
    // The held words must still all emerge, back to back.
    outs = 0;
    for (int c = 0; c < DEPTH; c++) begin
      apply(0, 1, 0, 0);
      if (o_out_valid) outs++;
      tick();
    end
    tests_run++; if (outs !== DEPTH) begin tests_failed++; $display("FAIL stall_words_kept got=%0d exp=%0d", outs, DEPTH); end
  endtask

  task automatic test_flush();
    idle(8);
    for (int c = 0; c < 3; c++) begin apply(1, 1, 0, 0); tick(); end
    apply(0, 1, 1, 0);
    tests_run++; if (o_occupancy !== 5'd3) begin tests_failed++; $display("FAIL flush_pre_occ got=%0d exp=3", o_occupancy); end
    tick();
    apply(0, 0, 0, 0);
    tests_run++; if (o_clear !== 1'b1 || o_stall !== 1'b0) begin tests_failed++; $display("FAIL flush_clear_stall got=%b%b exp=10", o_clear, o_stall); end
    tests_run++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_outputs got ov=%b ir=%b exp 0/0", o_out_valid, o_in_ready); end
    tick();
    apply(0, 1, 0, 0);
    tests_run++; if (o_occupancy !== 5'd0 || o_out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_after got occ=%0d ov=%b exp 0/0", o_occupancy, o_out_valid); end
    tests_run++; if (o_in_ready !== 1'b1 || o_clear !== 1'b0) begin tests_failed++; $display("FAIL flush_back_to_run got ir=%b clr=%b exp 1/0", o_in_ready, o_clear); end
    tick();
  endtask

  task automatic test_drain();
    int pulses;
    pulses = 0;
    idle(8);
    for (int c = 0; c < 2; c++) begin apply(1, 1, 0, 0); tick(); end
    apply(0, 1, 0, 1); tick();
    for (int c = 0; c < 20; c++) begin
      apply(pulses == 0, 1, 0, 0);
      if (o_drained) begin
        pulses++;
        tests_run++; if (o_occupancy !== 5'd0 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_done got occ=%0d ir=%b exp 0/1", o_occupancy, o_in_ready); end
      end else if (pulses == 0) begin
        tests_run++; if (o_in_ready !== 1'b0) begin tests_failed++; $display("FAIL drain_no_intake cyc=%0d got=%b exp=0", c, o_in_ready); end
      end
      tick();
    end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL drain_pulse_count got=%0d exp=1", pulses); end
    idle(8);
  endtask

  task automatic test_drain_empty();
    idle(8);
    apply(0, 1, 0, 1); tick();
    apply(1, 1, 0, 0);
    tests_run++; if (o_in_ready !== 1'b0 || o_drained !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_state got ir=%b drn=%b exp 0/0", o_in_ready, o_drained); end
    tick();
    apply(0, 1, 0, 0);
    tests_run++; if (o_drained !== 1'b1 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL drain_empty_pulse got drn=%b ir=%b exp 1/1", o_drained, o_in_ready); end
    tick();
    apply(0, 1, 0, 0);
    tests_run++; if (o_drained !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_one_cycle got=%b exp=0", o_drained); end
    tick();
  endtask

  task automatic test_flush_drain();
    int pulses;
    pulses = 0;
    idle(8);
    for (int c = 0; c < 2; c++) begin apply(1, 1, 0, 0); tick(); end
    apply(0, 1, 1, 1); tick();
    apply(0, 1, 0, 0);
    tests_run++; if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL flush_drain_clear got=%b exp=1", o_clear); end
    tick();
    for (int c = 0; c < 8; c++) begin
      apply(0, 1, 0, 0);
      if (o_drained) pulses++;
      tick();
    end
    apply(0, 1, 0, 0);
    tests_run++; if (pulses !== 0 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_drain_no_pulse got pulses=%0d ir=%b exp 0/1", pulses, o_in_ready); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    idle(8);
    for (int c = 0; c < 3; c++) begin apply(1, 0, 0, 0); tick(); end
    apply(0, 0, 0, 1); tick();
    apply(0, 0, 0, 0);
    tests_run++; if (o_in_ready !== 1'b0 || o_occupancy !== 5'd3) begin tests_failed++; $display("FAIL rst_drain_pre got ir=%b occ=%0d exp 0/3", o_in_ready, o_occupancy); end
    i_resetn = 1'b0;
    #1;
    model_reset();
    tests_run++; if (o_out_valid !== 1'b0 || o_stall !== 1'b0 || o_clear !== 1'b0) begin tests_failed++; $display("FAIL rst_drain_outs got ov=%b st=%b clr=%b exp 000", o_out_valid, o_stall, o_clear); end
    tests_run++; if (o_in_ready !== 1'b1 || o_occupancy !== 5'd0 || o_drained !== 1'b0) begin tests_failed++; $display("FAIL rst_drain_state got ir=%b occ=%0d drn=%b exp 1/0/0", o_in_ready, o_occupancy, o_drained); end
    @(negedge i_clk);
    i_resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply(0, 1, 0, 0);
      tests_run++; if (o_drained !== 1'b0 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_drain_after cyc=%0d got drn=%b ir=%b exp 0/1", c, o_drained, o_in_ready); end
      tick();
    end
  endtask

  task automatic test_random();
    bit inv, ordy, fl, dr;
    for (int c = 0; c < 600; c++) begin
      inv  = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 99) < ((c < 300) ? 80 : 30));
      fl   = ($urandom_range(0, 49) == 0);
      dr   = ($urandom_range(0, 29) == 0);
      apply(inv, ordy, fl, dr);
      tests_run++; if (o_out_valid !== e_ov) begin tests_failed++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, o_out_valid, e_ov); end
      tests_run++; if (o_stall !== e_stall) begin tests_failed++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, o_stall, e_stall); end
      tests_run++; if (o_in_ready !== e_ir) begin tests_failed++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, o_in_ready, e_ir); end
      tests_run++; if (o_clear !== e_clr) begin tests_failed++; $display("FAIL rand_clear cyc=%0d got=%b exp=%b", c, o_clear, e_clr); end
      tests_run++; if (int'(o_occupancy) !== e_occ) begin tests_failed++; $display("FAIL rand_occupancy cyc=%0d got=%0d exp=%0d", c, o_occupancy, e_occ); end
      tests_run++; if (o_drained !== e_drn) begin tests_failed++; $display("FAIL rand_drained cyc=%0d got=%b exp=%b", c, o_drained, e_drn); end
`ifdef PIPELINE_CTRL_STALL_STATS_EN
      tests_run++; if (int'(o_stall_cycles) !== m_stall_cnt) begin tests_failed++; $display("FAIL rand_stall_cycles cyc=%0d got=%0d exp=%0d", c, o_stall_cycles, m_stall_cnt); end
`endif
      tick();
    end
  endtask

  initial begin
    i_resetn = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0; i_flush = 1'b0; i_drain = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_drain();
    test_drain_empty();
    test_flush_drain();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of controlled pipeline stages (legal 1..16).
REQ-002 The block SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port i_resetn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port i_in_valid  input  1  upstream word valid.
REQ-005 The block SHALL have port o_in_ready  output  1  upstream word accepted this cycle when high with i_in_valid.
REQ-006 The block SHALL have port o_out_valid  output  1  last stage holds a valid word.
REQ-007 The block SHALL have port i_out_ready  input  1  downstream consumes the last-stage word.
REQ-008 The block SHALL have port i_flush  input  1  discard all in-flight words.
REQ-009 The block SHALL have port i_drain  input  1  stop intake and empty the pipeline.
REQ-010 The block SHALL have port o_stall  output  1  hold signal driven to every data stage.
REQ-011 The block SHALL have port o_clear  output  1  zero signal driven to every data stage.
REQ-012 The block SHALL have port o_drained  output  1  one-cycle pulse when a drain completes.
REQ-013 The block SHALL have port o_occupancy  output  5  count of valid words in flight (0..DEPTH).

Function
REQ-014 The block SHALL keep a valid vector v[DEPTH-1:0], where v[k] marks stage k as holding a valid word.
REQ-015 The block SHALL drive o_out_valid = v[DEPTH-1] AND state!=FLUSH.
REQ-016 The block SHALL drive o_stall = v[DEPTH-1] AND NOT i_out_ready AND state!=FLUSH; o_stall is combinational.
REQ-017 The block SHALL drive o_in_ready = NOT o_stall AND state==RUN.
REQ-018 When o_stall=0 and state!=FLUSH, the block SHALL shift v by one: v[0] <= i_in_valid AND o_in_ready, and v[k] <= v[k-1].
REQ-019 When o_stall=1, the block SHALL hold v unchanged.
REQ-020 Latency SHALL be exactly DEPTH cycles from acceptance to o_out_valid when there is no stall.
REQ-021 Full throughput SHALL be one word per cycle while i_out_ready=1.
REQ-022 The block SHALL have FSM states RUN, DRAIN and FLUSH, with these transitions:
- RUN -> FLUSH on i_flush.
- RUN -> DRAIN on i_drain and not i_flush.
- DRAIN -> FLUSH on i_flush.
- DRAIN -> RUN when o_occupancy==0 at a clock edge, pulsing o_drained=1 for exactly that following cycle.
- FLUSH -> RUN unconditionally after one cycle.
REQ-023 A drain requested with o_occupancy already 0 SHALL complete in one cycle (RUN->DRAIN->RUN, o_drained pulse).
REQ-024 In FLUSH, the block SHALL drive o_clear=1 and o_stall=0 (clear must win over hold in the stages), and SHALL set v to 0 and o_occupancy to 0 at the edge; outside FLUSH, o_clear=0.
REQ-025 The block SHALL update o_occupancy as a registered counter: +1 on accept, -1 on o_out_valid AND i_out_ready, unchanged when both occur.
REQ-026 o_occupancy SHALL always equal popcount(v) and SHALL never exceed DEPTH.
REQ-027 Words presented in DRAIN or FLUSH SHALL not be accepted (o_in_ready=0).
REQ-028 If i_flush and i_drain are asserted simultaneously, flush SHALL win.

Reset
REQ-029 On i_resetn low, the block SHALL set state=RUN, v=0, o_occupancy=0 and o_drained=0, giving o_stall=0, o_clear=0, o_out_valid=0 and o_in_ready=1 immediately.
REQ-030 Reset asserted mid-drain or mid-flush SHALL abort the operation with no o_drained pulse; after release the block SHALL be in RUN.

Configuration
REQ-031 With macro PIPELINE_CTRL_STALL_STATS_EN defined, the block SHALL add output port o_stall_cycles (16 bits), which counts cycles with o_stall=1, saturates at 0xFFFF, and resets to 0 on reset only.
REQ-032 Without PIPELINE_CTRL_STALL_STATS_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-033 With DEPTH=4: i_in_valid=1 for 6 cycles, i_out_ready=1 -> o_out_valid rises 4 cycles after first accept, stays high 6 cycles; o_occupancy peaks at 4.
REQ-034 Fill to occupancy 4, then i_out_ready=0 for 3 cycles -> o_stall=1 and o_in_ready=0 for those 3 cycles, v is held, and o_stall_cycles=3 (macro defined).
REQ-035 Occupancy 3, pulse i_flush -> next cycle o_clear=1 and o_stall=0; the following cycle o_occupancy=0, o_out_valid=0, state RUN.
REQ-036 Occupancy 2, assert i_drain, i_out_ready=1 -> o_in_ready=0 and o_drained pulses once after occupancy reaches 0.
REQ-037 i_flush and i_drain asserted together -> FLUSH taken, no o_drained pulse.
REQ-038 Assert i_resetn low during DRAIN with occupancy 3 -> all outputs at reset values immediately, no o_drained pulse.
